// File: rtl/iter_shifter.sv
// -----------------------------------------------------------------------------
// iter_shifter
//
// An iterative barrel shifter. It takes one request, then applies the shift
// amount one base-3 digit per clock. On RUN edge k it shifts the working
// register by d_k * 3^k. The latency is always STAGES cycles from accept to
// result, whatever the shift amount is.
//
// Parameters
//   WIDTH   data width (2..64)
//   SHW     shift-amount width, $clog2(WIDTH)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request present
//   in_ready   block is idle and can accept a request
//   in_data    operand
//   in_shamt   unsigned shift amount
//   in_mode    0 SLL, 1 SRA, 2 ROR, 3 SRL (or pass-through, see below)
//   out_valid  result present
//   out_ready  consumer accepts the result
//   out_data   result (meaningful only while out_valid is high)
//
// Build option
//   ITER_SHIFTER_SRL_EN  when defined, mode 3 is a logical right shift.
//                        When it is undefined, mode 3 returns the latched
//                        operand unchanged, with the same latency and
//                        handshake.
// -----------------------------------------------------------------------------
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // The smallest n for which 3^n >= 2^shw. This is the number of base-3
    // digits needed to cover every shift amount.
    function automatic int calc_stages(input int shw);
        longint p3;
        int     n;
        p3 = 1;
        n  = 0;
        for (int i = 0; i < 64; i++) begin
            if (p3 < (longint'(1) << shw)) begin
                p3 = p3 * 3;
                n  = n + 1;
            end
        end
        return n;
    endfunction

    function automatic int pow3(input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) begin
            p = p * 3;
        end
        return p;
    endfunction

    localparam int STAGES = calc_stages(SHW);
    localparam int CW     = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg,  work_next;
    logic [SHW-1:0]   rem_reg,   rem_next;   // digits of shamt that are not yet applied
    logic [1:0]       mode_reg,  mode_next;
    logic [CW-1:0]    cnt_reg,   cnt_next;

    logic [1:0]         digit;
    logic [31:0]        weight;
    logic [31:0]        amt;
    logic [31:0]        rot;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   shifted;

    // Shift datapath for the current stage. Amounts of WIDTH or more are
    // allowed here. Across stages the shifts add up, so shamt >= WIDTH gives
    // zero fill, sign fill, or a rotation by (shamt mod WIDTH).
    always_comb begin
        digit  = 2'(32'(rem_reg) % 32'd3);
        weight = 32'd0;
        for (int k = 0; k < STAGES; k++) begin
            if (cnt_reg == CW'(k)) begin
                weight = 32'(pow3(k));
            end
        end
        amt     = 32'(digit) * weight;
        rot     = amt % 32'(WIDTH);
        dbl     = {work_reg, work_reg} >> rot;
        shifted = work_reg;
        case (mode_reg)
            2'd0:    shifted = work_reg << amt;
            2'd1:    shifted = WIDTH'($signed(work_reg) >>> amt);
            2'd2:    shifted = dbl[WIDTH-1:0];
`ifdef ITER_SHIFTER_SRL_EN
            default: shifted = work_reg >> amt;
`else
            default: shifted = work_reg;
`endif
        endcase
    end

    // Next-state and next-value logic for the FSM.
    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        rem_next   = rem_reg;
        mode_next  = mode_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next  = in_data;
                    rem_next   = in_shamt;
                    mode_next  = in_mode;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                work_next = shifted;
                rem_next  = SHW'(32'(rem_reg) / 32'd3);
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == CW'(STAGES - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            rem_reg   <= '0;
            mode_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            rem_reg   <= rem_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = work_reg;

endmodule

// File: tb/tb_iter_shifter.sv
// -----------------------------------------------------------------------------
// tb_iter_shifter
//
// Self-checking bench for iter_shifter with WIDTH=16. The reference model
// computes each result bit by bit from the operand, so it does not follow
// the stage-by-stage structure of the design. The bench covers directed
// corner cases, randomized requests, back-pressure in DONE, and reset
// applied during RUN.
// -----------------------------------------------------------------------------
module tb_iter_shifter;

    localparam int WIDTH = 16;
    localparam int SHW   = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int checks = 0;
    int errors = 0;

    iter_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each result bit i comes from operand bit i+s (right shifts and
    // rotates) or bit i-s (left shift). Bits with no source operand bit take
    // the fill value.
    function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] d,
                                                   input int s, input int m);
        logic [WIDTH-1:0] r;
        r = d;
        for (int i = 0; i < WIDTH; i++) begin
            case (m)
                0: r[i] = (i - s >= 0) ? d[i - s] : 1'b0;
                1: r[i] = (i + s < WIDTH) ? d[i + s] : d[WIDTH-1];
                2: r[i] = d[(i + s) % WIDTH];
`ifdef ITER_SHIFTER_SRL_EN
                default: r[i] = (i + s < WIDTH) ? d[i + s] : 1'b0;
`else
                default: r[i] = d[i];
`endif
            endcase
        end
        return r;
    endfunction

    // Entered at a negedge. Presents a request and returns at the negedge
    // that follows the accept edge.
    task automatic send(input logic [WIDTH-1:0] d, input int s, input int m);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = SHW'(s);
        in_mode  = 2'(m);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts the rising edges after the accept edge until out_valid is seen.
    // The count is bounded, so a stuck design cannot hang the bench.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 20);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] d,
                          input int s, input int m);
        int lat;
        logic [WIDTH-1:0] exp;
        exp = ref_model(d, s, m);
        send(d, s, m);
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'd3);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        $display("op d=0x%04h s=%0d m=%0d -> 0x%04h (exp 0x%04h) lat=%0d",
                 d, s, m, out_data, exp, lat);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        logic [WIDTH-1:0] pend;
        logic             seen_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data",  64'(out_data),      64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op("sll_f1_4",    16'h00F1, 4, 0);
        check("sll_f1_4_val", 64'(ref_model(16'h00F1, 4, 0)), 64'h0F10);
        run_op("sra_8000_15", 16'h8000, 15, 1);
        run_op("sra_7fff_15", 16'h7FFF, 15, 1);
        run_op("ror_1_1",     16'h0001, 1, 2);
        run_op("ror_1234_0",  16'h1234, 0, 2);
        run_op("m3_8000_15",  16'h8000, 15, 3);
        run_op("sll_zero_sh", 16'hBEEF, 0, 0);
        run_op("sra_full",    16'hFFFF, 15, 1);

        // Randomized requests.
        for (int n = 0; n < 40; n++) begin
            run_op("rand", WIDTH'($urandom), int'($urandom_range(15, 0)),
                   int'($urandom_range(3, 0)));
        end

        // Back-pressure in DONE, with a new request waiting at the input.
        send(16'h00F1, 4, 0);
        wait_done(lat);
        check("hold_lat", 64'(lat), 64'd3);
        pend = 16'hA5C3;
        in_valid = 1'b1;
        in_shamt = SHW'(7);
        in_mode  = 2'd2;
        for (int c = 0; c < 5; c++) begin
            in_data = (c == 4) ? pend : WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_data",     64'(out_data),      64'h0F10);
            check("hold_in_ready", {63'd0, in_ready},  64'd0);
            check("hold_valid",    {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_in_ready",  {63'd0, in_ready},  64'd1);
        check("rel_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pend_accepted", {63'd0, in_ready}, 64'd0);
        wait_done(lat);
        check("pend_lat",  64'(lat),      64'd3);
        check("pend_data", 64'(out_data), 64'(ref_model(pend, 7, 2)));
        $display("pending op d=0x%04h -> 0x%04h", pend, out_data);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset asserted in the second RUN cycle.
        send(16'h1234, 5, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_in_ready",  {63'd0, in_ready},  64'd1);
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_data",  64'(out_data),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("arst_no_result", {63'd0, seen_valid}, 64'd0);
        $display("reset during RUN: result dropped");
        run_op("post_rst_sll", 16'h0001, 15, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits; legal range 2..64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width; not overridden by instantiators.
REQ-003 Localparam STAGES: smallest n with 3^n >= 2^SHW, which is 3 for WIDTH=16; it is the number of base-3 digits processed.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_shamt  input  SHW  shift amount, unsigned.
REQ-010 in_mode  input  2  operation: 0 SLL, 1 SRA, 2 ROR, 3 SRL.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  WIDTH  result.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE; both are registered-state decodes with no combinational path from inputs.
REQ-016 Accept edge: in IDLE with in_valid=1, the block SHALL latch data, shamt and mode, clear the digit counter, and enter RUN.
REQ-017 Each RUN edge k (k=0..STAGES-1) SHALL apply shift amount d_k*3^k to the working register, where d_k = (shamt/3^k) mod 3.
REQ-018 After the edge that applies digit STAGES-1, the block SHALL enter DONE.
REQ-019 Latency: out_valid SHALL rise exactly STAGES cycles after the accept edge, independent of shamt, including shamt=0.
REQ-020 SLL and SRL SHALL fill with zeros, SRA SHALL fill with the latched operand MSB, and ROR SHALL wrap bits shifted out of bit 0 into bit WIDTH-1.
REQ-021 If shamt >= WIDTH (possible when WIDTH is not a power of two), SLL/SRL SHALL yield 0, SRA SHALL yield all sign bits, and ROR SHALL rotate by shamt mod WIDTH; these results follow naturally from cumulative stage shifts.
REQ-022 In DONE, out_data SHALL be held stable until out_valid and out_ready are both high, after which the block SHALL return to IDLE on that edge.
REQ-023 Changes to in_* during RUN or DONE SHALL be ignored, as the block holds no second request.
REQ-024 Back-to-back throughput SHALL be one result per STAGES+2 cycles, with out_ready tied high and in_valid held high.
REQ-025 out_data outside DONE SHALL be the working register value and is not meaningful.

Reset
REQ-026 While rst=1, the FSM SHALL be forced immediately to IDLE: in_ready=1, out_valid=0, out_data=0, and digit counter=0.
REQ-027 Reset asserted during RUN or DONE SHALL discard the operation with no result emitted, and the first request after deassertion SHALL be processed normally.

Configuration
REQ-028 With macro ITER_SHIFTER_SRL_EN defined, mode 3 SHALL perform logical right shift per REQ-020/021.
REQ-029 Without ITER_SHIFTER_SRL_EN, mode 3 SHALL pass the latched operand through unchanged with identical latency and handshake, and no SRL datapath logic SHALL be synthesised.

Verification (WIDTH=16, STAGES=3)
REQ-030 SLL 0x00F1 by 4 -> out_data 0x0F10, out_valid high exactly 3 cycles after the accept edge.
REQ-031 SRA 0x8000 by 15 -> 0xFFFF, and SRA 0x7FFF by 15 -> 0x0000.
REQ-032 ROR 0x0001 by 1 -> 0x8000, and ROR 0x1234 by 0 -> 0x1234 with the same 3-cycle latency.
REQ-033 Mode 3, 0x8000 by 15 -> 0x0001 with ITER_SHIFTER_SRL_EN defined, and 0x8000 without it.
REQ-034 Hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new in_data toggling -> out_data constant, in_ready=0; raise out_ready -> IDLE next edge, and the pending request is accepted on the following edge.
REQ-035 Assert rst for 1 cycle in the second RUN cycle -> out_valid stays 0 and in_ready=1 immediately; the next request SLL 0x0001 by 15 -> 0x8000.
